// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) with one register stage per shift-amount bit,
// MSB first, valid/ready flow control and an SLL shifted-out-ones flag.
module barrel_shift_pipe #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_ovf
);

   localparam int         LAST     = SHAMT_W - 1;
   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_SRA = 2'b10;
   localparam logic [1:0] MODE_ROL = 2'b11;

   logic stall;

   for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      localparam int SH = 1 << (SHAMT_W - 1 - k);

      // Shift-amount bits still pending when a beat enters this stage; the MSB is consumed here.
      logic [SHAMT_W-1-k:0] src_shamt;
      logic [WIDTH-1:0]     src_data;
      logic [1:0]           src_mode;
      logic                 src_ovf;
      logic                 src_valid;

      logic [WIDTH-1:0]     res_data;
      logic                 res_ovf;
      logic [WIDTH-1:0]     data_d, data_q;
      logic                 ovf_d, ovf_q;
      logic                 valid_d, valid_q;

      if (k == 0) begin : g_first
         assign src_data  = in_data;
         assign src_shamt = in_shamt;
         assign src_mode  = in_mode;
         assign src_ovf   = 1'b0;
         assign src_valid = in_valid;
      end else begin : g_next
         assign src_data  = g_stage[k-1].data_q;
         assign src_shamt = g_stage[k-1].g_keep.shamt_q;
         assign src_mode  = g_stage[k-1].g_keep.mode_q;
         assign src_ovf   = g_stage[k-1].ovf_q;
         assign src_valid = g_stage[k-1].valid_q;
      end

      // Conditional power-of-two shift for this stage, then hold-or-advance selection.
      always_comb begin
         res_data = src_data;
         res_ovf  = 1'b0;
         if (src_shamt[SHAMT_W-1-k]) begin
            case (src_mode)
               MODE_SLL: begin
                  res_data = src_data << SH;
                  res_ovf  = src_ovf | (src_data[WIDTH-1 -: SH] != '0);
               end
               MODE_SRL: res_data = src_data >> SH;
               MODE_SRA: res_data = $signed(src_data) >>> SH;
               MODE_ROL: res_data = {src_data[WIDTH-1-SH:0], src_data[WIDTH-1 -: SH]};
               default:  res_data = src_data;
            endcase
         end else begin
            res_data = src_data;
            res_ovf  = src_ovf & (src_mode == MODE_SLL);
         end

         if (stall) begin
            data_d  = data_q;
            ovf_d   = ovf_q;
            valid_d = valid_q;
         end else begin
            data_d  = res_data;
            ovf_d   = res_ovf;
            valid_d = src_valid;
         end
      end

      // Stage register for data, overflow accumulator and valid.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            data_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
         end else begin
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
         end
      end

      // The final stage has no consumer for mode or remaining shift bits.
      if (k < LAST) begin : g_keep
         logic [SHAMT_W-2-k:0] shamt_d, shamt_q;
         logic [1:0]           mode_d, mode_q;

         // Carry mode and the not-yet-consumed shift bits to the next stage.
         always_comb begin
            if (stall) begin
               shamt_d = shamt_q;
               mode_d  = mode_q;
            end else begin
               shamt_d = src_shamt[SHAMT_W-2-k:0];
               mode_d  = src_mode;
            end
         end

         // Stage register for mode and remaining shift amount.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               shamt_q <= '0;
               mode_q  <= 2'b00;
            end else begin
               shamt_q <= shamt_d;
               mode_q  <= mode_d;
            end
         end
      end
   end

   // out_ready -> in_ready is the only combinational path through the block.
   assign stall     = g_stage[LAST].valid_q & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = g_stage[LAST].valid_q;
   assign out_data  = g_stage[LAST].data_q;
   assign out_ovf   = g_stage[LAST].ovf_q;

endmodule
